// File: rtl/pipe_step_ctrl_if.sv
// Front-panel request / pipeline control bundle for the debug sequencer.
// The master side is the panel and pipeline. The slave side is the sequencer.
interface pipe_step_ctrl_if #(
  parameter int PC_W  = 9,
  parameter int CNT_W = 32
);
  logic             step_req;
  logic             run_req;
  logic             halt_req;
  logic             clr_req;
  logic             bp_en;
  logic [PC_W-1:0]  bp_addr;
  logic [PC_W-1:0]  pc;
  logic             stall;
  logic             pipe_en;
  logic             pipe_rst;
  logic [1:0]       state;
  logic             bp_hit;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output step_req, run_req, halt_req, clr_req, bp_en, bp_addr, pc, stall,
    input  pipe_en, pipe_rst, state, bp_hit, cycle_cnt, stall_cnt
  );

  modport slave (
    input  step_req, run_req, halt_req, clr_req, bp_en, bp_addr, pc, stall,
    output pipe_en, pipe_rst, state, bp_hit, cycle_cnt, stall_cnt
  );
endinterface

// File: rtl/pipe_step_ctrl.sv
// Debug sequencer: turns debounced panel buttons into a registered pipeline
// clock-enable and clear pulse, with divided free-run, breakpoint and counters.
module pipe_step_ctrl #(
  parameter int PC_W      = 9,
  parameter int CNT_W     = 32,
  parameter int RUN_DIV   = 25000,
  parameter int FLUSH_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_step_ctrl_if.slave       bus
);
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam int FL_W  = $clog2(FLUSH_CYC + 1);
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(RUN_DIV - 1);
  localparam logic [FL_W-1:0]  FL_RELOAD  = FL_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_STEP  = 2'b01,
    S_RUN   = 2'b10,
    S_FLUSH = 2'b11
  } state_t;

  state_t           r_state;
  logic             r_pipe_en;
  logic             r_pipe_rst;
  logic             r_bp_hit;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [DIV_W-1:0] r_div;
  logic [FL_W-1:0]  r_flush_cnt;
  logic             r_skip_bp;
  logic             r_step_q;
  logic             r_run_q;
  logic             r_halt_q;
  logic             r_clr_q;

  logic w_step_edge;
  logic w_run_edge;
  logic w_halt_edge;
  logic w_clr_edge;
  logic w_tick;
  logic w_bp_match;
  logic w_go_flush;

  assign w_step_edge = bus.step_req & ~r_step_q;
  assign w_run_edge  = bus.run_req  & ~r_run_q;
  assign w_halt_edge = bus.halt_req & ~r_halt_q;
  assign w_clr_edge  = bus.clr_req  & ~r_clr_q;
  assign w_tick      = (r_div == '0);
  assign w_bp_match  = bus.bp_en && (bus.pc == bus.bp_addr) && !r_skip_bp;
  // clr outranks everything, but only IDLE and RUN listen for it
  assign w_go_flush  = w_clr_edge && ((r_state == S_IDLE) || (r_state == S_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pipe_en   <= 1'b0;
      r_pipe_rst  <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_div       <= DIV_RELOAD;
      r_flush_cnt <= FL_RELOAD;
      r_skip_bp   <= 1'b0;
      r_step_q    <= 1'b1;
      r_run_q     <= 1'b1;
      r_halt_q    <= 1'b1;
      r_clr_q     <= 1'b1;
    end else begin
      r_step_q <= bus.step_req;
      r_run_q  <= bus.run_req;
      r_halt_q <= bus.halt_req;
      r_clr_q  <= bus.clr_req;

      if (r_pipe_en && (r_state != S_FLUSH)) begin
        if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
        if (bus.stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          r_pipe_en <= 1'b0;
          if (w_halt_edge) begin
            r_state <= S_IDLE;
          end else if (w_step_edge) begin
            r_state   <= S_STEP;
            r_pipe_en <= 1'b1;
            r_bp_hit  <= 1'b0;
          end else if (w_run_edge) begin
            r_state   <= S_RUN;
            r_div     <= DIV_RELOAD;
            r_skip_bp <= 1'b1;
            r_bp_hit  <= 1'b0;
          end
        end
        S_STEP: begin
          r_state   <= S_IDLE;
          r_pipe_en <= 1'b0;
        end
        S_RUN: begin
          r_pipe_en <= 1'b0;
          r_div     <= w_tick ? DIV_RELOAD : r_div - 1'b1;
          if (w_halt_edge || w_run_edge) begin
            r_state <= S_IDLE;
          end else if (w_tick) begin
            if (w_bp_match) begin
              r_bp_hit <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_pipe_en <= 1'b1;
              r_skip_bp <= 1'b0;
            end
          end
        end
        default: begin
          r_cycle_cnt <= '0;
          r_stall_cnt <= '0;
          if (r_flush_cnt == '0) begin
            r_state    <= S_IDLE;
            r_pipe_en  <= 1'b0;
            r_pipe_rst <= 1'b0;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
      endcase

      // Placed last so it overrides whatever the state branch chose
      if (w_go_flush) begin
        r_state     <= S_FLUSH;
        r_pipe_en   <= 1'b1;
        r_pipe_rst  <= 1'b1;
        r_bp_hit    <= 1'b0;
        r_cycle_cnt <= '0;
        r_stall_cnt <= '0;
        r_flush_cnt <= FL_RELOAD;
      end
    end
  end

  assign bus.pipe_en   = r_pipe_en;
  assign bus.pipe_rst  = r_pipe_rst;
  assign bus.state     = r_state;
  assign bus.bp_hit    = r_bp_hit;
  assign bus.cycle_cnt = r_cycle_cnt;
  assign bus.stall_cnt = r_stall_cnt;
endmodule

// File: tb/tb_pipe_step_ctrl.sv
// Bench for pipe_step_ctrl: directed scenarios plus a random soak, all checked
// against a cycle-level behavioural model of the panel sequencer.
module tb_pipe_step_ctrl;
  localparam int PC_W      = 9;
  localparam int CNT_W     = 4;
  localparam int RUN_DIV   = 4;
  localparam int FLUSH_CYC = 4;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int VW        = 5 + 2 * CNT_W;
  localparam logic [1:0] M_IDLE = 2'b00, M_STEP = 2'b01, M_RUN = 2'b10, M_FLUSH = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_step_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  pipe_step_ctrl #(
    .PC_W(PC_W), .CNT_W(CNT_W), .RUN_DIV(RUN_DIV), .FLUSH_CYC(FLUSH_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] dut_vec;
  assign dut_vec = {bus.pipe_en, bus.pipe_rst, bus.state, bus.bp_hit, bus.cycle_cnt, bus.stall_cnt};

  // ---------------- reference model ----------------
  logic [1:0] m_mode = M_IDLE;
  bit m_en = 0, m_rst = 0, m_bp = 0, m_skip = 0;
  int m_cyc = 0, m_stl = 0, m_age = 0, m_flush_left = 0;
  bit p_step = 1, p_run = 1, p_halt = 1, p_clr = 1;

  function automatic logic [VW-1:0] exp_vec();
    return {m_en, m_rst, m_mode, m_bp, CNT_W'(m_cyc), CNT_W'(m_stl)};
  endfunction

  always @(posedge clk or posedge rst) begin
    bit e_step, e_run, e_halt, e_clr, go_flush;
    if (rst) begin
      m_mode = M_IDLE; m_en = 0; m_rst = 0; m_bp = 0; m_skip = 0;
      m_cyc = 0; m_stl = 0; m_age = 0; m_flush_left = 0;
      p_step = 1; p_run = 1; p_halt = 1; p_clr = 1;
    end else begin
      e_step = bus.step_req && !p_step;
      e_run  = bus.run_req  && !p_run;
      e_halt = bus.halt_req && !p_halt;
      e_clr  = bus.clr_req  && !p_clr;
      p_step = bus.step_req; p_run = bus.run_req; p_halt = bus.halt_req; p_clr = bus.clr_req;
      go_flush = 0;
      if (m_en && m_mode != M_FLUSH) begin
        m_cyc = (m_cyc < CNT_MAX) ? m_cyc + 1 : CNT_MAX;
        if (bus.stall) m_stl = (m_stl < CNT_MAX) ? m_stl + 1 : CNT_MAX;
      end
      case (m_mode)
        M_IDLE: begin
          if (e_clr) go_flush = 1;
          else if (e_halt) m_en = 0;
          else if (e_step) begin m_mode = M_STEP; m_en = 1; m_bp = 0; end
          else if (e_run) begin m_mode = M_RUN; m_age = 0; m_skip = 1; m_bp = 0; m_en = 0; end
          else m_en = 0;
        end
        M_STEP: begin m_mode = M_IDLE; m_en = 0; end
        M_RUN: begin
          m_age++;
          if (e_clr) go_flush = 1;
          else if (e_halt || e_run) begin m_mode = M_IDLE; m_en = 0; end
          else if (m_age % RUN_DIV == 0) begin
            if (bus.bp_en && bus.pc == bus.bp_addr && !m_skip) begin
              m_bp = 1; m_mode = M_IDLE; m_en = 0;
            end else begin
              m_en = 1; m_skip = 0;
            end
          end else m_en = 0;
        end
        default: begin
          m_flush_left--;
          if (m_flush_left == 0) begin m_mode = M_IDLE; m_en = 0; m_rst = 0; end
        end
      endcase
      if (go_flush) begin
        m_mode = M_FLUSH; m_en = 1; m_rst = 1; m_bp = 0;
        m_cyc = 0; m_stl = 0; m_flush_left = FLUSH_CYC;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_idle();
    bus.step_req = 0; bus.run_req = 0; bus.halt_req = 0; bus.clr_req = 0;
    bus.stall = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.step_req = 1; bus.run_req = 0; bus.halt_req = 0; bus.clr_req = 0;
    bus.bp_en = 0; bus.bp_addr = '0; bus.pc = '0; bus.stall = 0;
    cyc(3);
    n_checks++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL reset_values: got %h exp 0", dut_vec); end
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL held_step_model: got %h exp %h", dut_vec, exp_vec()); end
      n_checks++;
      if (bus.pipe_en !== 1'b0) begin n_fail++; $display("FAIL held_step_no_pulse: got %b exp 0", bus.pipe_en); end
    end
    bus.step_req = 0; cyc(1);
    bus.step_req = 1; cyc(1);
    n_checks++;
    if ({bus.state, bus.pipe_en} !== 3'b011) begin n_fail++; $display("FAIL step_pulse: got %b exp 011", {bus.state, bus.pipe_en}); end
    bus.step_req = 0; cyc(1);
    n_checks++;
    if ({bus.state, bus.pipe_en} !== 3'b000) begin n_fail++; $display("FAIL step_done: got %b exp 000", {bus.state, bus.pipe_en}); end
    n_checks++;
    if (bus.cycle_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL step_count: got %0d exp 1", bus.cycle_cnt); end
  endtask

  task automatic test_run_divider();
    logic [31:0] exp_q[$];
    int pulses = 0;
    for (int k = 1; k <= 5; k++) exp_q.push_back(32'(k * RUN_DIV));
    bus.run_req = 1; cyc(1);
    bus.run_req = 0;
    for (int i = 1; i <= 5 * RUN_DIV; i++) begin
      bus.stall = 1'($urandom_range(0, 1));
      cyc(1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL run_model: got %h exp %h", dut_vec, exp_vec()); end
      if (bus.pipe_en === 1'b1) begin
        pulses++;
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0] != 32'(i)) begin
          n_fail++; $display("FAIL run_pulse_pos: got cycle %0d exp %0d", i, (exp_q.size() != 0) ? exp_q[0] : 0);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    n_checks++;
    if (pulses != 5) begin n_fail++; $display("FAIL run_pulse_count: got %0d exp 5", pulses); end
    bus.stall = 0;
    bus.run_req = 1; cyc(1);
    bus.run_req = 0;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({bus.state, bus.pipe_en} !== 3'b000) begin n_fail++; $display("FAIL run_stopped: got %b exp 000", {bus.state, bus.pipe_en}); end
      cyc(1);
    end
  endtask

  task automatic test_breakpoint();
    int pulses = 0;
    bus.bp_en = 1; bus.bp_addr = PC_W'(5); bus.pc = PC_W'(3);
    bus.run_req = 1; cyc(1);
    bus.run_req = 0;
    for (int i = 0; i < 40 && bus.state !== M_IDLE; i++) begin
      cyc(1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL bp_model: got %h exp %h", dut_vec, exp_vec()); end
      if (bus.pipe_en === 1'b1) begin pulses++; bus.pc = bus.pc + 1'b1; end
    end
    n_checks++;
    if ({bus.state, bus.bp_hit} !== 3'b001) begin n_fail++; $display("FAIL bp_stop: got %b exp 001", {bus.state, bus.bp_hit}); end
    n_checks++;
    if (pulses != 2 || bus.pc !== PC_W'(5)) begin n_fail++; $display("FAIL bp_pulses: got %0d pc %0d exp 2 pc 5", pulses, bus.pc); end
    pulses = 0;
    bus.run_req = 1; cyc(1);
    bus.run_req = 0;
    for (int i = 1; i <= 3 * RUN_DIV; i++) begin
      cyc(1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL bp_skip_model: got %h exp %h", dut_vec, exp_vec()); end
      if (bus.pipe_en === 1'b1) begin pulses++; bus.pc = bus.pc + 1'b1; end
    end
    n_checks++;
    if (pulses != 3 || bus.bp_hit !== 1'b0) begin n_fail++; $display("FAIL bp_skip: got %0d hit %b exp 3 hit 0", pulses, bus.bp_hit); end
    bus.halt_req = 1; cyc(1);
    bus.halt_req = 0;
    n_checks++;
    if (bus.state !== M_IDLE) begin n_fail++; $display("FAIL bp_halt: got %b exp 00", bus.state); end
    bus.bp_en = 0;
  endtask

  task automatic test_flush();
    int rst_cycles = 0;
    bus.clr_req = 1;
    for (int i = 1; i <= 6; i++) begin
      cyc(1);
      if (i == 1) bus.clr_req = 0;
      if (i == 2) bus.step_req = 1;
      if (i == 3) bus.step_req = 0;
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL flush_model: got %h exp %h", dut_vec, exp_vec()); end
      if (dut_vec === {1'b1, 1'b1, M_FLUSH, 1'b0, {(2*CNT_W){1'b0}}}) rst_cycles++;
    end
    n_checks++;
    if (rst_cycles != FLUSH_CYC) begin n_fail++; $display("FAIL flush_len: got %0d exp %0d", rst_cycles, FLUSH_CYC); end
    n_checks++;
    if ({bus.state, bus.pipe_rst, bus.pipe_en} !== 4'b0000) begin n_fail++; $display("FAIL flush_exit: got %b exp 0000", {bus.state, bus.pipe_rst, bus.pipe_en}); end
  endtask

  task automatic test_priority();
    logic pat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bus.clr_req = 1; bus.step_req = 1; cyc(1);
    n_checks++;
    if (bus.state !== M_FLUSH) begin n_fail++; $display("FAIL prio_clr_step: got %b exp 11", bus.state); end
    bus.clr_req = 0; bus.step_req = 0; cyc(FLUSH_CYC + 1);
    bus.halt_req = 1; bus.run_req = 1; cyc(1);
    n_checks++;
    if ({bus.state, bus.pipe_en} !== 3'b000) begin n_fail++; $display("FAIL prio_halt_run: got %b exp 000", {bus.state, bus.pipe_en}); end
    bus.halt_req = 0; bus.run_req = 0; cyc(1);
    bus.run_req = 1; cyc(1);
    bus.run_req = 0; cyc(RUN_DIV - 1);
    bus.halt_req = 1; cyc(1);
    n_checks++;
    if ({bus.state, bus.pipe_en} !== 3'b000) begin n_fail++; $display("FAIL prio_tick_halt: got %b exp 000", {bus.state, bus.pipe_en}); end
    n_checks++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL prio_model: got %h exp %h", dut_vec, exp_vec()); end
    bus.halt_req = 0;
    bus.clr_req = 1; cyc(1);
    bus.clr_req = 0; cyc(FLUSH_CYC + 1);
    for (int k = 0; k < 5; k++) begin
      bus.step_req = 1; cyc(1);
      bus.step_req = 0; bus.stall = pat[k]; cyc(1);
      bus.stall = 0;
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL stall_model: got %h exp %h", dut_vec, exp_vec()); end
    end
    n_checks++;
    if (bus.cycle_cnt !== CNT_W'(5) || bus.stall_cnt !== CNT_W'(3)) begin
      n_fail++; $display("FAIL stall_counts: got %0d/%0d exp 5/3", bus.cycle_cnt, bus.stall_cnt);
    end
  endtask

  task automatic test_saturate();
    for (int k = 0; k < 20; k++) begin
      bus.step_req = 1; cyc(1);
      bus.step_req = 0; cyc(1);
    end
    cyc(1);
    n_checks++;
    if (bus.cycle_cnt !== CNT_W'(CNT_MAX)) begin n_fail++; $display("FAIL cnt_saturate: got %0d exp %0d", bus.cycle_cnt, CNT_MAX); end
    n_checks++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL saturate_model: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_async_reset();
    bit seen = 0;
    bus.run_req = 1; cyc(1);
    bus.run_req = 0;
    for (int i = 0; i < 3 * RUN_DIV && !seen; i++) begin
      cyc(1);
      if (bus.pipe_en === 1'b1) seen = 1;
    end
    n_checks++;
    if (!seen) begin n_fail++; $display("FAIL arst_pulse: got none exp pipe_en pulse"); end
    #2 rst = 1;
    #1;
    n_checks++;
    if (dut_vec !== '0) begin n_fail++; $display("FAIL arst_async: got %h exp 0", dut_vec); end
    cyc(1);
    rst = 0;
    cyc(2);
    n_checks++;
    if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL arst_after: got %h exp %h", dut_vec, exp_vec()); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cyc(1);
      n_checks++;
      if (dut_vec !== exp_vec()) begin n_fail++; $display("FAIL random_model cyc %0d: got %h exp %h", i, dut_vec, exp_vec()); end
      if ($urandom_range(0, 7) == 0) bus.step_req = ~bus.step_req;
      if ($urandom_range(0, 7) == 0) bus.run_req  = ~bus.run_req;
      if ($urandom_range(0, 11) == 0) bus.halt_req = ~bus.halt_req;
      if ($urandom_range(0, 23) == 0) bus.clr_req  = ~bus.clr_req;
      bus.stall = 1'($urandom_range(0, 1));
      bus.bp_en = ($urandom_range(0, 3) != 0);
      bus.pc    = PC_W'($urandom_range(0, 5));
      if ($urandom_range(0, 15) == 0) bus.bp_addr = PC_W'($urandom_range(0, 5));
    end
  endtask

  initial begin
    test_reset();
    test_run_divider();
    test_breakpoint();
    drive_idle();
    test_flush();
    test_priority();
    test_saturate();
    drive_idle();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_step_ctrl.md
Name: pipe_step_ctrl

Overview:
- Debug sequencer for the 5-stage pipeline. Generates a registered clock-enable (pipe_en) and a pipeline-clear pulse (pipe_rst) from debounced front-panel requests.
- Supports single-step, free-run at a divided rate, halt, PC breakpoint and pipeline flush.
- Keeps cycle and stall counters for the LCD status line.
- Sits between the button debouncers and the pipeline registers/PC. Every pipeline register is gated by pipe_en.

Parameters:
- PC_W, 9, width of the fetch PC compared against the breakpoint.
- CNT_W, 32, width of cycle_cnt and stall_cnt.
- RUN_DIV, 25000, clk cycles per pipe_en pulse in RUN; legal range ≥2.
- FLUSH_CYC, 4, cycles pipe_rst is held in FLUSH; legal range ≥1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- step_req  in  1  debounced level; rising edge requests one pipeline cycle
- run_req  in  1  debounced level; rising edge toggles RUN
- halt_req  in  1  debounced level; rising edge stops RUN
- clr_req  in  1  debounced level; rising edge flushes the pipeline
- bp_en  in  1  breakpoint enable
- bp_addr  in  PC_W  breakpoint PC
- pc  in  PC_W  current fetch PC (o_pc)
- stall  in  1  pipeline load-use/data-hazard stall
- pipe_en  out  1  pipeline clock enable, registered
- pipe_rst  out  1  synchronous pipeline clear, registered
- state  out  2  IDLE=00, STEP=01, RUN=10, FLUSH=11
- bp_hit  out  1  sticky; set when RUN stopped on breakpoint
- cycle_cnt  out  CNT_W  pipeline cycles executed since last flush
- stall_cnt  out  CNT_W  executed cycles during which stall was 1

Behaviour:
- Reset (async): state=IDLE; pipe_en=0, pipe_rst=0, bp_hit=0; cycle_cnt=0, stall_cnt=0; divider=RUN_DIV-1; skip_bp=0. Edge-detect history registers reset to 1, so a button held through reset release produces no edge.
- Edge detect: req & ~req_q, evaluated every clk.
- Priority of simultaneous edges: clr > halt > step > run.
- All outputs are registered. Each output is a function of state/counters after the clock edge.
- IDLE: pipe_en=0.
  - clr edge -> FLUSH.
  - else step edge -> STEP.
  - else run edge -> RUN.
  - halt edge: ignored.
  - step, run or clr edge clears bp_hit.
- STEP: one-cycle state; pipe_en=1 for exactly that cycle; next state IDLE. Any edge arriving in STEP is dropped, except clr, which is taken next from IDLE only if still rising. Edges are never queued.
- RUN:
  - On entry: divider=RUN_DIV-1, skip_bp=1.
  - Each cycle the divider decrements. At divider==0 it reloads to RUN_DIV-1 and a tick occurs.
  - On a tick with bp_en=1, pc==bp_addr and skip_bp=0: no pulse; bp_hit<=1; next state IDLE.
  - Otherwise on a tick: pipe_en=1 for one cycle; skip_bp<=0.
  - skip_bp lets RUN leave a PC that already equals bp_addr.
  - run edge or halt edge -> IDLE immediately; a tick in the same cycle is suppressed.
  - clr edge -> FLUSH.
  - step edge: ignored.
  - Pulse spacing is exactly RUN_DIV clk cycles. The first pulse comes RUN_DIV cycles after the entry cycle.
- FLUSH:
  - pipe_rst=1 and pipe_en=1 for FLUSH_CYC consecutive cycles, so gated registers see the clear.
  - cycle_cnt and stall_cnt are held at 0; bp_hit=0.
  - Then IDLE with pipe_rst=0.
  - All request edges during FLUSH are ignored.
- Counters: on every cycle with pipe_en=1 and state≠FLUSH, cycle_cnt+1. If stall=1 in that cycle, stall_cnt+1 as well. Both saturate at all-ones; no wrap.
- rst asserted mid-RUN or mid-FLUSH aborts immediately to reset values. pipe_en/pipe_rst drop asynchronously.
- pc, bp_addr and bp_en are sampled only on RUN ticks. Changing them in other states has no effect.

Test Plan:
- Reset release with step_req held high -> no pulse, state=00. Release, then press step -> exactly one pipe_en cycle, cycle_cnt=1, state 01 then 00.
- RUN_DIV=4: run edge, wait 20 clk -> pipe_en pulses at cycles 4, 8, 12, 16, 20 after entry (5 pulses, 1 cycle wide). Run edge again -> state=00, no further pulses.
- bp_en=1, bp_addr=5, pc advancing 3,4,5 per pulse -> stops at first tick with pc=5, no pulse on that tick, bp_hit=1. Run again with pc=5 -> first tick pulses (skip_bp), pc=6 continues.
- FLUSH_CYC=4, counters nonzero -> clr edge: pipe_rst=pipe_en=1 for exactly 4 cycles; cycle_cnt=stall_cnt=0; step edges during flush ignored; state back to 00.
- Same-cycle clr+step, halt+run, and tick+halt -> FLUSH taken; RUN not entered/exited per priority; tick suppressed. stall=1 on 3 of 5 stepped cycles -> stall_cnt=3, cycle_cnt=5.
- CNT_W=4: 20 steps -> cycle_cnt saturates at 15. Assert rst mid-RUN -> outputs reset asynchronously before the next clk edge.
